// File: rtl/rot_pixel_pingpong_buf_pkg.sv
// Package rot_buf_pkg: default sizing constants for the ping-pong pixel buffer.
// It also provides a constant-evaluable clog2 used to derive address widths.
// This file has no ports.
package rot_buf_pkg;

  localparam int PIX_W      = 8;   // bits per pixel byte
  localparam int HBUS_LANES = 4;   // bytes per AHB write beat
  localparam int IMG_DEPTH  = 64;  // pixel entries per bank
  localparam int RGB_PORTS  = 3;   // read ports (B, G, R)

  // Bank index; there are exactly two banks.
  typedef logic bank_sel_t;

  // Returns at least 1, so a single-entry bank still gets a one-bit address.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rot_pixel_pingpong_buf_if.sv
// Bus bundle between the AHB write path, the rotate engine read side and the
// ping-pong buffer.
//   master: drives the write beat, read strobe/addresses and done pulses.
//   slave : the buffer; returns the ready flags, pixels, level and error.
interface rot_pixel_pingpong_buf_if
  import rot_buf_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int LANES    = HBUS_LANES,
  parameter int DEPTH    = IMG_DEPTH,
  parameter int RD_PORTS = RGB_PORTS,
  parameter int ADDR_W   = clog2(DEPTH)
) ();

  logic                         I_WR_EN;
  logic [ADDR_W-1:0]            I_WR_ADDR;
  logic [LANES-1:0]             I_WR_BE;
  logic [LANES*DATA_W-1:0]      I_HWDATA;
  logic                         I_WR_DONE;
  logic                         O_WR_READY;
  logic                         I_RD_EN;
  logic [RD_PORTS*ADDR_W-1:0]   I_RD_ADDR;
  logic [RD_PORTS*DATA_W-1:0]   O_PIXEL;
  logic                         O_RD_VALID;
  logic                         I_RD_DONE;
  logic                         O_RD_READY;
  logic [1:0]                   O_BANK_LEVEL;
  logic                         O_ERR;

  modport master (
    output I_WR_EN, I_WR_ADDR, I_WR_BE, I_HWDATA, I_WR_DONE,
    output I_RD_EN, I_RD_ADDR, I_RD_DONE,
    input  O_WR_READY, O_PIXEL, O_RD_VALID, O_RD_READY, O_BANK_LEVEL, O_ERR
  );

  modport slave (
    input  I_WR_EN, I_WR_ADDR, I_WR_BE, I_HWDATA, I_WR_DONE,
    input  I_RD_EN, I_RD_ADDR, I_RD_DONE,
    output O_WR_READY, O_PIXEL, O_RD_VALID, O_RD_READY, O_BANK_LEVEL, O_ERR
  );

endinterface

// File: rtl/rot_pixel_pingpong_buf_bank.sv
// rot_pixel_bank: one DEPTH x DATA_W pixel bank.
// Ports:
//   clk, rst_n        clock and async active-low reset (read registers only)
//   wr_en/addr/be/data LANES-wide masked write; lane k targets wr_addr+k,
//                      and lanes past the end of the bank are dropped
//   rd_en, rd_addr    RD_PORTS packed read addresses, one strobe for all
//   rd_data           registered read data; holds while rd_en is low
module rot_pixel_bank
  import rot_buf_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int LANES    = HBUS_LANES,
  parameter int DEPTH    = IMG_DEPTH,
  parameter int RD_PORTS = RGB_PORTS,
  parameter int ADDR_W   = clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [LANES-1:0]           wr_be,
  input  logic [LANES*DATA_W-1:0]    wr_data,
  input  logic                       rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [ADDR_W-1:0]          lane_addr [LANES];
  logic [LANES-1:0]           lane_ok;
  logic [RD_PORTS*DATA_W-1:0] rd_data_d, rd_data_q;

  // Range check is done in int arithmetic so base+k cannot wrap.
  always_comb begin
    lane_ok = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_addr[k] = wr_addr + ADDR_W'(k);
      lane_ok[k]   = (int'(wr_addr) + k) < DEPTH;
    end
  end

  // Pixel storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en && wr_be[k] && lane_ok[k]) begin
        mem[lane_addr[k]] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (int'(rd_addr[p*ADDR_W +: ADDR_W]) < DEPTH) begin
          rd_data_d[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rot_pixel_pingpong_buf.sv
// rot_pixel_pingpong_buf: two-bank pixel buffer between the AHB write path
// and the rotate engine. The bus fills the bank at wr_ptr while the engine
// reads the bank at rd_ptr; banks change hands through done pulses.
// Ports:
//   I_HCLK      clock
//   I_HRESET_N  async active-low reset
//   bus         slave side of rot_pixel_pingpong_buf_if (write beat, read
//               strobe/addresses, done pulses, ready flags, pixels, level,
//               sticky error)
module rot_pixel_pingpong_buf
  import rot_buf_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int LANES    = HBUS_LANES,
  parameter int DEPTH    = IMG_DEPTH,
  parameter int RD_PORTS = RGB_PORTS,
  parameter int ADDR_W   = clog2(DEPTH)
) (
  input  logic                     I_HCLK,
  input  logic                     I_HRESET_N,
  rot_pixel_pingpong_buf_if.slave  bus
);

  logic [1:0] full_q, full_d;
  bank_sel_t  wr_ptr_q, wr_ptr_d;
  bank_sel_t  rd_ptr_q, rd_ptr_d;
  bank_sel_t  rd_sel_q, rd_sel_d;   // bank that produced the last read
  logic       rd_valid_q, rd_valid_d;
  logic       err_q, err_d;

  logic       wr_ready, rd_ready;
  logic       wr_acc, wr_done_acc, rd_acc, rd_done_acc;
  logic [1:0] bank_we, bank_re;
  logic [RD_PORTS*DATA_W-1:0] bank_rdata [2];

  // The write bank is never full and the read bank always is, so the two
  // pointers can never select the same bank for an accepted operation.
  always_comb begin
    wr_ready    = !full_q[wr_ptr_q];
    rd_ready    = full_q[rd_ptr_q];
    wr_acc      = bus.I_WR_EN   && wr_ready;
    wr_done_acc = bus.I_WR_DONE && wr_ready;
    rd_acc      = bus.I_RD_EN   && rd_ready;
    rd_done_acc = bus.I_RD_DONE && rd_ready;

    bank_we = '0;
    bank_re = '0;
    if (wr_acc) bank_we[wr_ptr_q] = 1'b1;
    if (rd_acc) bank_re[rd_ptr_q] = 1'b1;
  end

  always_comb begin
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_sel_d   = rd_sel_q;
    rd_valid_d = rd_acc;
    err_d      = err_q;

    if (wr_done_acc) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (rd_done_acc) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = !rd_ptr_q;
    end
    if (rd_acc) rd_sel_d = rd_ptr_q;

    if ((bus.I_WR_EN || bus.I_WR_DONE) && !wr_ready) err_d = 1'b1;
    if ((bus.I_RD_EN || bus.I_RD_DONE) && !rd_ready) err_d = 1'b1;
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rot_pixel_bank #(
      .DATA_W   (DATA_W),
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .RD_PORTS (RD_PORTS),
      .ADDR_W   (ADDR_W)
    ) u_bank (
      .clk     (I_HCLK),
      .rst_n   (I_HRESET_N),
      .wr_en   (bank_we[b]),
      .wr_addr (bus.I_WR_ADDR),
      .wr_be   (bus.I_WR_BE),
      .wr_data (bus.I_HWDATA),
      .rd_en   (bank_re[b]),
      .rd_addr (bus.I_RD_ADDR),
      .rd_data (bank_rdata[b])
    );
  end

  // Both banks' read registers hold between reads, so muxing by the bank of
  // the last read keeps O_PIXEL stable across a read-bank handover.
  assign bus.O_PIXEL      = bank_rdata[rd_sel_q];
  assign bus.O_RD_VALID   = rd_valid_q;
  assign bus.O_WR_READY   = wr_ready;
  assign bus.O_RD_READY   = rd_ready;
  assign bus.O_BANK_LEVEL = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign bus.O_ERR        = err_q;

endmodule
